// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types and constants for the immediate-generator stage.
// Provides the imm_fmt_t format tag, the RV32I/RV64I opcodes that carry an
// immediate, and the funct3 codes that split OP-IMM / OP-IMM-32 decoding.
package imm_gen_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_SH   = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_t;

    localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;

    localparam logic [F3_W-1:0] F3_ADDI = 3'b000;
    localparam logic [F3_W-1:0] F3_SLLI = 3'b001;
    localparam logic [F3_W-1:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: purely combinational immediate extraction for one instruction.
// Ports:
//   inst   - raw 32-bit instruction word
//   imm_c  - XLEN-wide sign-/zero-extended immediate
//   fmt_c  - imm_fmt_t format tag (FMT_NONE for unsupported opcodes)
//   err_c  - unsupported opcode flag (only with IMMGEN_ERR_EN defined)
// Every immediate is first formed as a signed 32-bit value and then widened
// to XLEN with one signed cast, so RV32 and RV64 share the same datapath.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   imm_c,
    output imm_fmt_t          fmt_c
`ifdef IMMGEN_ERR_EN
    ,
    output logic              err_c
`endif
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam bit          IS_RV64 = (XLEN == 64);

    logic [OPC_W-1:0]   opcode;
    logic [F3_W-1:0]    funct3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic signed [31:0] imm_u;
    logic signed [31:0] shamt;
    logic signed [31:0] shamt_w;
    logic signed [31:0] imm32;
    logic               unsup;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign imm_i   = {{20{inst[31]}}, inst[31:20]};
    assign imm_s   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u   = {inst[31:12], 12'b0};
    // shift amounts exclude the funct7 bits above them
    assign shamt   = 32'(inst[20 +: SHAMT_W]);
    assign shamt_w = 32'(inst[24:20]);

    // format select
    always_comb begin
        imm32 = '0;
        fmt_c = FMT_NONE;
        unsup = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm32 = imm_i;
                fmt_c = FMT_I;
            end
            OPC_OPIMM: begin
                if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
                    imm32 = shamt;
                    fmt_c = FMT_SH;
                end else begin
                    imm32 = imm_i;
                    fmt_c = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                // word-sized ops only exist on RV64
                if (IS_RV64 && funct3 == F3_ADDI) begin
                    imm32 = imm_i;
                    fmt_c = FMT_I;
                end else if (IS_RV64 && (funct3 == F3_SLLI || funct3 == F3_SRXI)) begin
                    imm32 = shamt_w;
                    fmt_c = FMT_SH;
                end else begin
                    unsup = 1'b1;
                end
            end
            OPC_STORE: begin
                imm32 = imm_s;
                fmt_c = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = imm_b;
                fmt_c = FMT_B;
            end
            OPC_JAL: begin
                imm32 = imm_j;
                fmt_c = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = imm_u;
                fmt_c = FMT_U;
            end
            default: begin
                unsup = 1'b1;
            end
        endcase
    end

    // signed cast sign-extends to XLEN
    assign imm_c = XLEN'(imm32);

`ifdef IMMGEN_ERR_EN
    assign err_c = unsup;
`else
    logic unused_unsup;
    assign unused_unsup = unsup;
`endif

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered decode-stage immediate generator with a 2-entry
// skid buffer (main output register + one skid register).
// Ports:
//   clk, reset      - core clock, asynchronous active-high reset
//   flush           - synchronous kill of every buffered entry (highest priority)
//   in_valid/in_ready/inst_code   - instruction input handshake
//   out_valid/out_ready           - result output handshake
//   imm_out, fmt_out              - registered immediate and format tag
//   err_out         - unsupported-opcode flag (only with IMMGEN_ERR_EN defined)
// in_ready is registered from the next state, so it never depends
// combinationally on out_ready.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm_out,
    output imm_fmt_t          fmt_out
`ifdef IMMGEN_ERR_EN
    ,
    output logic              err_out
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            drain;
    logic            ld_main_dec;
    logic            ld_main_skid;
    logic            ld_skid;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic [XLEN-1:0] skid_imm;
    imm_fmt_t        skid_fmt;
`ifdef IMMGEN_ERR_EN
    logic            dec_err;
    logic            skid_err;
`endif

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst  (inst_code),
        .imm_c (dec_imm),
        .fmt_c (dec_fmt)
`ifdef IMMGEN_ERR_EN
        ,
        .err_c (dec_err)
`endif
    );

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // next state and register load enables
    always_comb begin
        state_nxt    = state;
        ld_main_dec  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt   = ST_FULL;
                        ld_main_dec = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        ld_main_dec = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_SKID;
                        ld_skid   = 1'b1;
                    end else if (drain) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        state_nxt    = ST_FULL;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // state and handshake registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_SKID);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    // main and skid payload registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_out  <= '0;
            fmt_out  <= FMT_NONE;
            skid_imm <= '0;
            skid_fmt <= FMT_NONE;
`ifdef IMMGEN_ERR_EN
            err_out  <= 1'b0;
            skid_err <= 1'b0;
`endif
        end else begin
            if (ld_main_dec) begin
                imm_out <= dec_imm;
                fmt_out <= dec_fmt;
`ifdef IMMGEN_ERR_EN
                err_out <= dec_err;
`endif
            end else if (ld_main_skid) begin
                imm_out <= skid_imm;
                fmt_out <= skid_fmt;
`ifdef IMMGEN_ERR_EN
                err_out <= skid_err;
`endif
            end
            if (ld_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
`ifdef IMMGEN_ERR_EN
                skid_err <= dec_err;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench for imm_gen_stage. Accepted instructions
// push a reference-model result; a negedge monitor pops and compares on every
// drain and checks the handshake against the scoreboard occupancy.
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            err;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_code;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    imm_fmt_t        fmt_out;
`ifdef IMMGEN_ERR_EN
    logic            err_out;
`endif

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    imm_gen_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_code (inst_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_out   (imm_out),
        .fmt_out   (fmt_out)
`ifdef IMMGEN_ERR_EN
        ,
        .err_out   (err_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic longint sext(input longint v, input int n);
        if (v[n-1]) return v - (longint'(1) << n);
        return v;
    endfunction

    // reference model: immediates assembled arithmetically from the field rules
    function automatic exp_t ref_model(input logic [31:0] ins);
        exp_t       e;
        longint     v  = 0;
        logic [2:0] f3 = ins[14:12];
        e.fmt = FMT_NONE;
        e.err = 1'b0;
        case (ins[6:0])
            OPC_LOAD, OPC_JALR: begin
                v = sext(longint'(ins[31:20]), 12); e.fmt = FMT_I;
            end
            OPC_OPIMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    v = longint'(ins[20 +: SHAMT_W]); e.fmt = FMT_SH;
                end else begin
                    v = sext(longint'(ins[31:20]), 12); e.fmt = FMT_I;
                end
            end
            OPC_OPIMM32: begin
                if (XLEN == 64 && f3 == 3'd0) begin
                    v = sext(longint'(ins[31:20]), 12); e.fmt = FMT_I;
                end else if (XLEN == 64 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    v = longint'(ins[24:20]); e.fmt = FMT_SH;
                end else begin
                    e.err = 1'b1;
                end
            end
            OPC_STORE: begin
                v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); e.fmt = FMT_S;
            end
            OPC_BRANCH: begin
                v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                       + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
                e.fmt = FMT_B;
            end
            OPC_JAL: begin
                v = sext(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096
                       + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
                e.fmt = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                v = sext(longint'(ins[31:12]) * 4096, 32); e.fmt = FMT_U;
            end
            default: e.err = 1'b1;
        endcase
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [10];
        logic [31:0] r;
        opcs = '{OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE,
                 OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, 7'h7F};
        r = $urandom();
        return {r[31:7], opcs[$urandom_range(0, 9)]};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            chk("out_valid_vs_sb", 64'(out_valid), 64'(sb.size() != 0));
            chk("in_ready_vs_sb", 64'(in_ready), 64'(sb.size() < 2));
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_imm", 64'(imm_out), 64'(e.imm));
                        chk("sb_fmt", 64'(fmt_out), 64'(e.fmt));
`ifdef IMMGEN_ERR_EN
                        chk("sb_err", 64'(err_out), 64'(e.err));
`endif
                    end
                end
                if (in_valid && in_ready) sb.push_back(ref_model(inst_code));
            end
        end
    end

    task automatic send_check(input string nm, input logic [31:0] ins,
                              input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                              input logic exp_err);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        inst_code = ins;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'(1));
        chk({nm, "_imm"}, 64'(imm_out), 64'(exp_imm[XLEN-1:0]));
        chk({nm, "_fmt"}, 64'(fmt_out), 64'(exp_fmt));
`ifdef IMMGEN_ERR_EN
        chk({nm, "_err"}, 64'(err_out), 64'(exp_err));
`else
        if (exp_err) chk({nm, "_none"}, 64'(fmt_out), 64'(FMT_NONE));
`endif
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst_code = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_imm", 64'(imm_out), 64'(0));
        chk("reset_fmt", 64'(fmt_out), 64'(FMT_NONE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready), 64'(1));

        // directed decode vectors
        send_check("addi_m1", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
        send_check("beq_m4", 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0);
        send_check("lui", 32'h123452B7, 64'h0000_0000_1234_5000, FMT_U, 1'b0);
        send_check("srai31", 32'h41F0D093, 64'h0000_0000_0000_001F, FMT_SH, 1'b0);
        send_check("sw_m8", 32'hFE112C23, 64'hFFFF_FFFF_FFFF_FFF8, FMT_S, 1'b0);
        send_check("jal_p8", 32'h008000EF, 64'h0000_0000_0000_0008, FMT_J, 1'b0);
        send_check("unsup", 32'h0000007F, 64'h0, FMT_NONE, 1'b1);

        // backpressure fills both entries
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'h00500093;
        @(posedge clk); #1;
        inst_code = 32'h00A00093;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_hold_imm", 64'(imm_out), 64'(5));
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", 64'(imm_out), 64'(5));
        @(negedge clk);
        chk("bp_second", 64'(imm_out), 64'(10));
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'(0));

        // flush in SKID with simultaneous in_valid
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'h00100093;
        @(posedge clk); #1;
        inst_code = 32'h00200093;
        @(posedge clk); #1;
        flush = 1'b1; inst_code = 32'h00300093;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_skid_valid", 64'(out_valid), 64'(0));
        chk("flush_skid_ready", 64'(in_ready), 64'(1));

        // flush in FULL drops an otherwise legal accept
        @(posedge clk); #1;
        in_valid = 1'b1; inst_code = 32'h00400093;
        @(posedge clk); #1;
        flush = 1'b1; inst_code = 32'h00600093;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_full_valid", 64'(out_valid), 64'(0));

        // async reset mid-transfer
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; inst_code = 32'h00700093;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 chk("pre_reset_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(out_valid), 64'(0));
        chk("async_reset_imm", 64'(imm_out), 64'(0));
        chk("async_reset_fmt", 64'(fmt_out), 64'(FMT_NONE));
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("after_reset_ready", 64'(in_ready), 64'(1));

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            inst_code = rand_inst();
            flush     = ($urandom_range(0, 31) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_drain", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts one instruction word per valid/ready handshake and extracts the sign-extended XLEN-wide immediate for every RV32I/RV64I format, including AUIPC, JALR and OP-IMM-32.
- Tags each result with its format code.
- Sits between fetch/IF-ID and the ID/EX register; a 2-entry skid buffer gives full throughput under backpressure and supports a pipeline flush.

Parameters:
- XLEN, 32, datapath and immediate width; legal values 32 or 64.
- SHAMT_W, ($clog2(XLEN)), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of every buffered entry
- in_valid  input  1  inst_code is valid
- in_ready  output  1  stage can accept an instruction
- inst_code  input  32  raw instruction word
- out_valid  output  1  imm_out/fmt_out are valid
- out_ready  input  1  consumer accepts the result
- imm_out  output  XLEN  sign-/zero-extended immediate
- fmt_out  output  3  imm_fmt_t format tag
- err_out  output  1  unsupported opcode; present only with IMMGEN_ERR_EN

Behaviour:
Reset and storage
- Reset is asynchronous, active-high. On reset:
  - out_valid=0, imm_out=0, fmt_out=FMT_NONE, err_out=0.
  - Skid entry is cleared.
  - in_ready=1 on the first cycle after reset deasserts.
- Storage consists of a main output register and one skid register.
- States:
  - EMPTY: main empty.
  - FULL: main valid, skid empty.
  - SKID: both valid.
- in_ready = (state != SKID). It is a registered signal and has no combinational path from out_ready.

Transfers
- An accept occurs when in_valid && in_ready.
- A drain occurs when out_valid && out_ready.
- EMPTY + accept -> FULL. The decoded result appears on imm_out one cycle after the accept (latency 1).
- FULL + accept + drain -> FULL, main reloaded with the new result.
- FULL + accept, no drain -> SKID, new result stored in skid.
- FULL + drain only -> EMPTY.
- SKID + drain -> FULL, skid moves to main. No accept is possible in SKID.
- Results leave in the order they were accepted. Outputs stay stable while out_valid && !out_ready.

Flush
- flush has priority over every other event that cycle.
- It moves the stage to EMPTY and drops any accept in the same cycle.
- out_valid=0 next cycle.

Decode (combinational, registered on capture)
- opcode 0000011 (LOAD), 1100111 (JALR), 0010011 with funct3 in {000, 010, 011, 100, 110, 111}: I format, sign-extend inst[31:20].
- 0010011 with funct3 in {001, 101}: SH format, zero-extend inst[20+SHAMT_W-1:20]. funct7 bits are excluded from the immediate.
- 0011011 (OP-IMM-32):
  - XLEN=64 only.
  - funct3 000 gives I format.
  - funct3 001/101 gives SH format with a 5-bit shamt.
  - With XLEN=32 this opcode is unsupported.
- 0100011: S format, sign-extend {inst[31:25], inst[11:7]}.
- 1100011: B format, sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- 1101111: J format, sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- 0110111 (LUI), 0010111 (AUIPC): U format, {inst[31:12], 12'b0}, sign-extended to XLEN.
- Any other opcode: imm=0, fmt=FMT_NONE.

Optional Feature:
- Macro: IMMGEN_ERR_EN.
- When defined, the err_out port exists. It is registered alongside imm_out and is set when the decoded opcode is unsupported (including OP-IMM-32 with XLEN=32). err_out travels through the skid buffer with its entry.
- When not defined, the port is absent and unsupported opcodes silently yield imm=0/FMT_NONE.

Decomposition:
- Package imm_gen_pkg contains:
  - typedef enum logic [2:0] imm_fmt_t: FMT_NONE, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J.
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC.
- Sub-module imm_decode (purely combinational, parametrised by XLEN) produces imm/fmt/err. imm_gen_stage instantiates it and owns the skid FSM.

Test Plan:
- XLEN=32, inst 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> one cycle later imm_out=0xFFFFFFFF, fmt=FMT_I.
- inst 0xFE000EE3 (beq -4) -> imm_out=0xFFFFFFFC, fmt=FMT_B. With XLEN=64 -> 0xFFFFFFFFFFFFFFFC.
- inst 0x123452B7 (lui x5,0x12345) -> 0x12345000, FMT_U. inst 0x41F0D093 (srai x1,x1,31) -> 0x0000001F, FMT_SH.
- Backpressure: feed 0x00500093 then 0x00A00093 back-to-back with out_ready=0 for 3 cycles:
  - in_ready=0 after the 2nd accept.
  - On release, imm_out is 5 then 10 on consecutive cycles; no loss or duplication.
- Flush while in SKID with a simultaneous in_valid -> out_valid=0 next cycle, in_ready=1, the flushed entries are never output, and the same-cycle input is dropped.
- Async reset asserted mid-transfer (out_valid=1) -> out_valid/imm_out clear immediately without waiting for clk. With IMMGEN_ERR_EN, inst 0x0000007F -> err_out=1, imm_out=0, fmt=FMT_NONE.
